// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - two-source writeback arbiter, drain FIFO and per-register pending tracker
// Optional WB_BYPASS_EN: a granted legal write skips an empty FIFO and retires in the same cycle.
module regfile_writeback #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int NREGS      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  input  logic                          rf_stall,
  output logic                          rf_write_enable,
  output logic [ADDR_W-1:0]             rf_write_addr,
  output logic [DATA_W-1:0]             rf_write_data,
  input  logic [ADDR_W-1:0]             chk_addr1,
  input  logic [ADDR_W-1:0]             chk_addr2,
  output logic                          chk_busy1,
  output logic                          chk_busy2,
  output logic [$clog2(FIFO_DEPTH):0]   pending_count,
  output logic                          err_addr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W:0] NREGS_L = NREGS[ADDR_W:0];

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     reg_cnt [NREGS];
  logic              prio_mem;

  logic              full, empty, alu_take, mem_take, accept, legal;
  logic              push, pop, bypass;
  logic [ADDR_W-1:0] sel_addr, head_addr;
  logic [DATA_W-1:0] sel_data, head_data;
  logic [NREGS-1:0]  inc_vec, dec_vec;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Each ready looks only at the other source's valid, never its own.
  assign alu_ready = !full && (!mem_valid || !prio_mem);
  assign mem_ready = !full && (!alu_valid || prio_mem);

  assign alu_take = alu_valid && alu_ready;
  assign mem_take = mem_valid && mem_ready;
  assign accept   = alu_take || mem_take;
  assign sel_addr = alu_take ? alu_addr : mem_addr;
  assign sel_data = alu_take ? alu_data : mem_data;
  assign legal    = ({1'b0, sel_addr} < NREGS_L);

`ifdef WB_BYPASS_EN
  assign bypass = empty && !rf_stall && accept && legal;
`else
  assign bypass = 1'b0;
`endif

  assign push      = accept && legal && !bypass;
  assign pop       = !empty && !rf_stall;
  assign head_addr = fifo_addr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  always_comb begin
    rf_write_enable = pop || bypass;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    if (pop) begin
      rf_write_addr = head_addr;
      rf_write_data = head_data;
    end else if (bypass) begin
      rf_write_addr = sel_addr;
      rf_write_data = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      prio_mem <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      // Winner of a contested cycle hands priority to the loser.
      if (alu_valid && mem_valid && accept) prio_mem <= !prio_mem;
      if (accept && !legal) err_addr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= sel_addr;
      fifo_data[wr_ptr] <= sel_data;
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 0; i < NREGS; i++) begin
      inc_vec[i] = push && (sel_addr == ADDR_W'(i));
      dec_vec[i] = pop && (head_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (reset)                        reg_cnt[i] <= '0;
      else if (inc_vec[i] && !dec_vec[i]) reg_cnt[i] <= reg_cnt[i] + CW'(1);
      else if (!inc_vec[i] && dec_vec[i]) reg_cnt[i] <= reg_cnt[i] - CW'(1);
    end
  end

  // Out-of-range check addresses match no counter and so read as idle.
  always_comb begin
    chk_busy1 = 1'b0;
    chk_busy2 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (chk_addr1 == ADDR_W'(i) && reg_cnt[i] != '0) chk_busy1 = 1'b1;
      if (chk_addr2 == ADDR_W'(i) && reg_cnt[i] != '0) chk_busy2 = 1'b1;
    end
  end

  assign pending_count = count;

endmodule
